// File: rtl/uart_rx_fifo_if.sv
// Receive-side word handshake: head-of-FIFO word and its error flags, with consumer ready.
// Latency: none, this interface only groups wires.
// Backpressure: the consumer holds data_out_ready low to stall; data_out_valid stays high while words wait.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        output data_out,
        output data_out_valid,
        output parity_err,
        output frame_err,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  parity_err,
        input  frame_err,
        output data_out_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (DATA_BITS/PARITY/STOP_BITS configurable) feeding a show-ahead word FIFO with per-word error flags.
// Latency: word pushed in the cycle of the final stop-bit sample, valid next cycle; UART_RX_MAJORITY_EN adds 2-of-3 majority sampling and one cycle.
// Backpressure: data_out_ready stalls the FIFO; a frame completing while the FIFO is full (and not popping) is dropped and overrun pulses.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUDRATE   = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           data_rx,
    uart_rx_fifo_if.master out_if,
    output logic           overrun,
    output logic           busy
);
    localparam int BIT_CYCLES  = CLK_FREQ / BAUDRATE;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES + 1);
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int EW          = DATA_BITS + 2;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                 rx_m, rx_s;
    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_flag, frm_flag;
    logic                 expiry, smp_stb, smp_bit;
    logic                 push;
    logic [EW-1:0]        push_dat;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= data_rx;
            rx_s <= rx_m;
        end
    end

    // Bit timer: half a bit to mid-start, then free-running whole bits until the frame ends
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_IDLE) begin
            cnt <= rx_s ? '0 : CNT_W'(HALF_CYCLES);
        end else if (cnt == CNT_W'(1)) begin
            cnt <= CNT_W'(BIT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expiry = (state != S_IDLE) && (cnt == CNT_W'(1));

`ifdef UART_RX_MAJORITY_EN
    logic rx_d1, rx_d2, exp_d;

    // Keep the two previous line samples; decide one cycle after expiry using expiry-1/expiry/expiry+1
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
            exp_d <= 1'b0;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
            exp_d <= expiry;
        end
    end

    assign smp_stb = exp_d;
    assign smp_bit = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
    assign smp_stb = expiry;
    assign smp_bit = rx_s;
`endif

    // Frame FSM: start check, LSB-first data shift, optional parity, stop bits
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_flag <= 1'b0;
            frm_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state    <= S_START;
                        bit_cnt  <= '0;
                        par_flag <= 1'b0;
                        frm_flag <= 1'b0;
                    end
                end
                S_START: begin
                    if (smp_stb) state <= smp_bit ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (smp_stb) begin
                        shreg <= {smp_bit, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (smp_stb) begin
                        // Odd parity wants the XOR over data+parity to be 1, even wants 0
                        par_flag <= ((^shreg) ^ smp_bit) != (PARITY == 1);
                        state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (smp_stb) begin
                        frm_flag <= frm_flag | ~smp_bit;
                        if (bit_cnt == 4'(STOP_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The last stop sample is folded straight into the pushed flag
    assign push     = (state == S_STOP) && smp_stb && (bit_cnt == 4'(STOP_BITS - 1));
    assign push_dat = {par_flag, frm_flag | ~smp_bit, shreg};
    assign busy     = (state != S_IDLE);

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full, pop, wr_en;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign pop   = !empty && out_if.data_out_ready;
    assign wr_en = push && (!full || pop);

    // FIFO pointers, occupancy and the overrun pulse for a dropped word
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overrun <= push && full && !pop;
        end
    end

    // Storage needs no reset: outputs are gated to zero while empty
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_dat;
    end

    assign out_if.data_out_valid = !empty;
    assign out_if.data_out       = empty ? '0 : mem[rd_ptr][DATA_BITS-1:0];
    assign out_if.frame_err      = !empty && mem[rd_ptr][DATA_BITS];
    assign out_if.parity_err     = !empty && mem[rd_ptr][DATA_BITS+1];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and an 8E2 instance at 10 clocks per bit.
// Directed frames cover flags, glitch rejection, overrun and mid-frame reset; a random run uses a queue model.
// Popped words are logged on the falling edge and compared against expectations in the main sequence.
module tb_uart_rx_fifo;
    localparam int BITC = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic rx_a, rx_p;
    logic ovr_a, ovr_p, busy_a, busy_p;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo_if #(.DATA_BITS(8)) if_a ();
    uart_rx_fifo_if #(.DATA_BITS(8)) if_p ();

    uart_rx_fifo #(
        .CLK_FREQ(1_000_000), .BAUDRATE(100_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(rst), .data_rx(rx_a), .out_if(if_a.master),
        .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_fifo #(
        .CLK_FREQ(1_000_000), .BAUDRATE(100_000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_p (
        .clk(clk), .rst(rst), .data_rx(rx_p), .out_if(if_p.master),
        .overrun(ovr_p), .busy(busy_p)
    );

    // Observed traffic: {parity_err, frame_err, data} per popped word
    logic [9:0] got_a[$];
    logic [9:0] got_p[$];
    int vcyc_a = 0;
    int busy_cyc_a = 0;
    int ovr_cnt_a = 0;
    int ovr_cnt_p = 0;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (if_a.data_out_valid) vcyc_a++;
            if (busy_a) busy_cyc_a++;
            if (ovr_a) ovr_cnt_a++;
            if (ovr_p) ovr_cnt_p++;
            if (if_a.data_out_valid && if_a.data_out_ready)
                got_a.push_back({if_a.parity_err, if_a.frame_err, if_a.data_out});
            if (if_p.data_out_valid && if_p.data_out_ready)
                got_p.push_back({if_p.parity_err, if_p.frame_err, if_p.data_out});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // A low final stop bit is released early so the line idles high before the receiver re-arms
    task automatic send_a(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_a = f[i];
            if (i == 9 && !f[i]) begin
                tick(7);
                rx_a = 1'b1;
                tick(3);
            end else begin
                tick(BITC);
            end
        end
        rx_a = 1'b1;
    endtask

    task automatic send_p(input logic [7:0] d, input logic pbit, input logic [1:0] st);
        logic [11:0] f;
        f = {st[1], st[0], pbit, d, 1'b0};
        for (int i = 0; i < 12; i++) begin
            rx_p = f[i];
            if (i == 11 && !f[i]) begin
                tick(7);
                rx_p = 1'b1;
                tick(3);
            end else begin
                tick(BITC);
            end
        end
        rx_p = 1'b1;
    endtask

    task automatic wait_a(input int n);
        for (int i = 0; i < 500 && got_a.size() < n; i++) tick(1);
    endtask

    task automatic wait_p(input int n);
        for (int i = 0; i < 500 && got_p.size() < n; i++) tick(1);
    endtask

    logic [9:0] mq[$];
    logic [9:0] exp_q[$];
    logic [7:0] d;
    logic       pbit, r, perr, ferr;
    logic [1:0] st;
    int         base, ob, vb, bb, exp_ovr;

    initial begin
        rx_a = 1'b1;
        rx_p = 1'b1;
        if_a.data_out_ready = 1'b0;
        if_p.data_out_ready = 1'b0;
        rst = 1'b1;
        tick(4);

        // Reset state
        chk("rst_data", 32'(if_a.data_out), 0);
        chk("rst_valid", 32'(if_a.data_out_valid), 0);
        chk("rst_perr", 32'(if_a.parity_err), 0);
        chk("rst_ferr", 32'(if_a.frame_err), 0);
        chk("rst_ovr", 32'(ovr_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_p_valid", 32'(if_p.data_out_valid), 0);
        chk("rst_p_busy", 32'(busy_p), 0);
        rst = 1'b0;
        tick(5);

        // 8N1 good frame, consumer always ready: valid for exactly one cycle
        if_a.data_out_ready = 1'b1;
        base = got_a.size();
        vb = vcyc_a;
        send_a(8'hA5, 1'b1);
        wait_a(base + 1);
        tick(5);
        chk("a5_count", 32'(got_a.size() - base), 1);
        chk("a5_word", 32'(got_a[base]), 32'h0A5);
        chk("a5_vcyc", 32'(vcyc_a - vb), 1);

        // Low stop bit flagged, next good frame clears it
        base = got_a.size();
        send_a(8'h55, 1'b0);
        tick(20);
        send_a(8'h0F, 1'b1);
        wait_a(base + 2);
        tick(5);
        chk("ferr_count", 32'(got_a.size() - base), 2);
        chk("ferr_word", 32'(got_a[base]), 32'h155);
        chk("ferr_next", 32'(got_a[base + 1]), 32'h00F);

        // Three-cycle glitch: brief busy, nothing pushed
        base = got_a.size();
        vb = vcyc_a;
        bb = busy_cyc_a;
        rx_a = 1'b0;
        tick(3);
        rx_a = 1'b1;
        tick(30);
        chk("glitch_busy", 32'((busy_cyc_a - bb) > 0 && (busy_cyc_a - bb) <= 10), 1);
        chk("glitch_nopush", 32'(got_a.size() - base), 0);
        chk("glitch_novalid", 32'(vcyc_a - vb), 0);
        chk("glitch_idle", 32'(busy_a), 0);

        // Fill with the consumer stalled; the fifth word overflows
        if_a.data_out_ready = 1'b0;
        ob = ovr_cnt_a;
        for (int k = 1; k <= 4; k++) begin
            send_a(8'(k), 1'b1);
            tick(15);
        end
        chk("fill_no_ovr", 32'(ovr_cnt_a - ob), 0);
        chk("fill_head", 32'(if_a.data_out), 32'h01);
        chk("fill_valid", 32'(if_a.data_out_valid), 1);
        send_a(8'h05, 1'b1);
        tick(15);
        chk("ovr_once", 32'(ovr_cnt_a - ob), 1);
        base = got_a.size();
        if_a.data_out_ready = 1'b1;
        tick(10);
        chk("drain_count", 32'(got_a.size() - base), 4);
        for (int k = 0; k < 4; k++)
            chk("drain_word", 32'(got_a[base + k]), 32'(k + 1));
        chk("drain_valid", 32'(if_a.data_out_valid), 0);

        // Reset mid-frame flushes the FIFO and drops the partial word
        if_a.data_out_ready = 1'b0;
        send_a(8'h99, 1'b1);
        tick(5);
        chk("pre_rst_valid", 32'(if_a.data_out_valid), 1);
        ob = ovr_cnt_a;
        rx_a = 1'b0;
        tick(BITC);
        rx_a = 1'b1;
        tick(BITC);
        rx_a = 1'b1;
        tick(BITC);
        rx_a = 1'b0;
        tick(4);
        rst = 1'b1;
        rx_a = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("post_rst_valid", 32'(if_a.data_out_valid), 0);
        chk("post_rst_data", 32'(if_a.data_out), 0);
        chk("post_rst_busy", 32'(busy_a), 0);
        if_a.data_out_ready = 1'b1;
        tick(20);
        base = got_a.size();
        send_a(8'h88, 1'b1);
        wait_a(base + 1);
        tick(10);
        chk("rst_rx_count", 32'(got_a.size() - base), 1);
        chk("rst_rx_word", 32'(got_a[base]), 32'h088);
        chk("rst_no_ovr", 32'(ovr_cnt_a - ob), 0);

        // Even parity, two stop bits: 0x3C has an even number of ones
        if_p.data_out_ready = 1'b1;
        base = got_p.size();
        send_p(8'h3C, 1'b1, 2'b11);
        tick(15);
        send_p(8'h3C, 1'b0, 2'b11);
        wait_p(base + 2);
        tick(5);
        chk("par_count", 32'(got_p.size() - base), 2);
        chk("par_bad", 32'(got_p[base]), 32'h23C);
        chk("par_good", 32'(got_p[base + 1]), 32'h03C);

        // Random frames against a frame-level queue model of the 4-deep buffer
        base = got_p.size();
        ob = ovr_cnt_p;
        exp_ovr = 0;
        mq.delete();
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            r    = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            pbit = 1'($urandom);
            st[0] = ($urandom_range(0, 3) != 0);
            st[1] = ($urandom_range(0, 3) != 0);
            perr = 1'((($countones(d) + int'(pbit)) % 2) != 0);
            ferr = !(st[0] && st[1]);
            if_p.data_out_ready = r;
            if (r) while (mq.size() > 0) exp_q.push_back(mq.pop_front());
            if (!r && mq.size() == 4) exp_ovr++;
            else mq.push_back({perr, ferr, d});
            if (r) while (mq.size() > 0) exp_q.push_back(mq.pop_front());
            send_p(d, pbit, st);
            tick(15);
        end
        if_p.data_out_ready = 1'b1;
        while (mq.size() > 0) exp_q.push_back(mq.pop_front());
        tick(20);
        chk("rnd_count", 32'(got_p.size() - base), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            chk("rnd_word", 32'(got_p[base + k]), 32'(exp_q[k]));
        chk("rnd_ovr", 32'(ovr_cnt_p - ob), 32'(exp_ovr));
        chk("end_valid_p", 32'(if_p.data_out_valid), 0);
        chk("end_busy_p", 32'(busy_p), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver for the FPGA test platform: deserialises asynchronous serial frames with configurable data width, parity and stop bits, checks each frame, and buffers received words in a small show-ahead FIFO behind a valid/ready handshake. It sits between the board RX pin and the AES command/data loader. It replaces fixed 8N1, unbuffered reception with error reporting and back-pressure tolerance.

## Interface
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- BAUDRATE, 115_200: line rate; BIT_CYCLES = CLK_FREQ/BAUDRATE (integer division, must be ≥ 4), HALF_CYCLES = BIT_CYCLES/2.
- DATA_BITS, 8: data bits per frame, legal 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal 1 or 2.
- FIFO_DEPTH, 4: word buffer depth, power of two ≥ 2.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_rx  in  1  asynchronous serial input, idle high.
- data_out  out  DATA_BITS  head-of-FIFO word, LSB = first received bit.
- data_out_valid  out  1  FIFO non-empty; data_out/flags valid.
- data_out_ready  in  1  consumer accepts head word when high with data_out_valid.
- parity_err  out  1  head word had a parity mismatch (0 when PARITY = 0).
- frame_err  out  1  head word had a low stop bit.
- overrun  out  1  one-cycle pulse: completed frame dropped because FIFO full.
- busy  out  1  frame in progress (state ≠ IDLE).

## Operation
- data_rx passes through a 2-flop synchroniser (reset value 1); all sampling uses the synchronised bit rx_s.
- FSM: IDLE, START, DATA, PARITY, STOP.
- IDLE: on rx_s = 0, load bit counter with HALF_CYCLES, go to START.
- START: at counter expiry sample rx_s; 1 → false start, back to IDLE, nothing pushed; 0 → reload BIT_CYCLES, go to DATA.
- DATA: sample at each expiry, shift LSB first; after DATA_BITS samples go to PARITY (PARITY ≠ 0) or STOP.
- PARITY: sample; parity_err flag = (XOR of data bits ^ sampled bit) ≠ expected (odd: total XOR must be 1; even: 0).
- STOP: sample each of STOP_BITS stop bits at mid-bit; any 0 sets frame flag. After the last stop sample, push {flags, word} and return to IDLE the same cycle, so a start edge arriving half a bit later is caught.
- A frame with frame_err is still pushed with its flag; consumer decides.
- FIFO: show-ahead; data_out, parity_err, frame_err reflect head entry; pop on data_out_valid & data_out_ready.
- Push when full: word dropped, contents unchanged, overrun pulses 1 cycle. Push and pop in the same cycle while full: both proceed, no overrun.
- Pop when empty ignored.

## Timing
- Reset: state IDLE, FIFO empty, counters 0; data_out = 0, data_out_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0.
- rx_s lags data_rx by 2 cycles; start sample at HALF_CYCLES after the detected falling edge, subsequent samples every BIT_CYCLES.
- Push occurs in the cycle of the final stop-bit sample; data_out_valid rises the following cycle when FIFO was empty.
- Pop takes effect next cycle; back-to-back pops at one word per cycle.
- rst mid-frame: partial frame discarded, FIFO flushed, no overrun pulse; new frame detection begins cycle after rst deasserts.

## Configuration
- UART_RX_MAJORITY_EN: when defined, each sample (start, data, parity, stop) is the 2-of-3 majority of rx_s at expiry-1, expiry, expiry+1 cycles; decision and pushes move one cycle later. Without it, single sample at counter expiry.

## Test plan
- CLK_FREQ=1_000_000, BAUDRATE=100_000 (BIT_CYCLES=10), 8N1, send 0xA5 with ready=1 → data_out=0xA5, valid 1 cycle, both error flags 0.
- PARITY=2, send 0x3C with parity bit 1 → data_out=0x3C, parity_err=1; with parity bit 0 → parity_err=0.
- 8N1, send 0x55 with stop bit forced 0 → data_out=0x55, frame_err=1; next 0x0F with good stop → frame_err=0.
- 3-cycle low glitch on idle line → busy rises then falls, no push, data_out_valid stays 0.
- ready=0, send 0x01..0x05 → overrun pulses once on fifth frame; then popping yields 0x01,0x02,0x03,0x04, valid drops.
- Assert rst during DATA of 0x77, then send 0x88 → only 0x88 received, no overrun.
